// File: rtl/vga_line_fetch.sv
//==============================================================================
// Module   : vga_line_fetch
// Purpose  : Ping-pong line buffer pixel source for the 800x480 B/W VGA timing
//            generator; fetches the next line from a word-addressed frame store.
//            Optional checkerboard test pattern: VGA_LF_TEST_PATTERN_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module vga_line_fetch #(
    parameter int H_ACTIVE = 800,
    parameter int H_TOTAL  = 976,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 528,
    parameter int WORD_W   = 16,
    parameter int ADDR_W   = 18
) (
    input  logic              CLOCK_PIXEL,
    input  logic              RESET,
    input  logic [10:0]       PIXEL_H,
    input  logic [10:0]       PIXEL_V,
    input  logic [ADDR_W-1:0] FRAME_BASE,
`ifdef VGA_LF_TEST_PATTERN_EN
    input  logic              TEST_MODE,
`endif
    output logic              PIXEL,
    output logic              MEM_REQ,
    output logic [ADDR_W-1:0] MEM_ADDR,
    input  logic              MEM_ACK,
    input  logic [WORD_W-1:0] MEM_DATA,
    output logic              UNDERRUN,
    input  logic              UNDERRUN_CLR
);

    localparam int WORDS_PER_LINE = H_ACTIVE / WORD_W;
    localparam int BIT_W          = $clog2(WORD_W);
    localparam int CNT_W          = $clog2(WORDS_PER_LINE);

    localparam logic [10:0]       c_h_active  = 11'(H_ACTIVE);
    localparam logic [10:0]       c_h_last    = 11'(H_TOTAL - 1);
    localparam logic [10:0]       c_v_active  = 11'(V_ACTIVE);
    localparam logic [10:0]       c_v_last    = 11'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  c_last_word = CNT_W'(WORDS_PER_LINE - 1);
    localparam logic [ADDR_W-1:0] c_line_step = ADDR_W'(WORDS_PER_LINE);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
    logic                fetch_bank_q, fetch_bank_d;
    logic                underrun_q, underrun_d;
    logic [WORD_W-1:0]   line_buf_q [2][WORDS_PER_LINE];
    logic [WORD_W-1:0]   line_buf_d [2][WORDS_PER_LINE];

    logic [10:0]         w_target;
    logic                w_target_valid;
    logic                w_wr_en;
    logic                w_abort;
    logic                w_active;
    logic [CNT_W-1:0]    w_rd_idx;
    logic                w_buf_pix;
    logic                w_pix_src;

    // Line after the last one wraps to line 0 of the next frame.
    assign w_target       = (PIXEL_V == c_v_last) ? 11'd0 : PIXEL_V + 11'd1;
    assign w_target_valid = (w_target < c_v_active);

    //--------------------------------------------------------------------------
    // Fetch state machine
    //--------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        line_addr_d  = line_addr_q;
        fetch_bank_d = fetch_bank_q;
        w_wr_en      = 1'b0;
        w_abort      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((PIXEL_H == 11'd0) && w_target_valid) begin
                    state_d      = ST_REQ;
                    word_cnt_d   = '0;
                    fetch_bank_d = w_target[0];
                    line_addr_d  = (w_target == 11'd0) ? FRAME_BASE
                                                       : line_addr_q + c_line_step;
                end
            end
            ST_REQ: begin
                // Deadline beats a same-cycle ack: the late word is dropped.
                if (PIXEL_H == c_h_last) begin
                    w_abort = 1'b1;
                    state_d = ST_IDLE;
                end else if (MEM_ACK) begin
                    w_wr_en    = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == c_last_word) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        underrun_d = underrun_q;
        if (w_abort) begin
            underrun_d = 1'b1;
        end else if (UNDERRUN_CLR) begin
            underrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_PIXEL or posedge RESET) begin
        if (RESET) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            line_addr_q  <= '0;
            fetch_bank_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            line_addr_q  <= line_addr_d;
            fetch_bank_q <= fetch_bank_d;
            underrun_q   <= underrun_d;
        end
    end

    //--------------------------------------------------------------------------
    // Line buffer: an aborted fetch blanks the words it never received.
    // Writes only occur from ST_REQ, which RESET clears asynchronously.
    //--------------------------------------------------------------------------
    always_comb begin
        line_buf_d = line_buf_q;
        if (w_wr_en) begin
            line_buf_d[fetch_bank_q][word_cnt_q] = MEM_DATA;
        end
        if (w_abort) begin
            for (int w = 0; w < WORDS_PER_LINE; w++) begin
                if (CNT_W'(w) >= word_cnt_q) begin
                    line_buf_d[fetch_bank_q][w] = '0;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_PIXEL) begin
        line_buf_q <= line_buf_d;
    end

    //--------------------------------------------------------------------------
    // Zero-latency pixel output
    //--------------------------------------------------------------------------
    assign w_active  = (PIXEL_H < c_h_active) && (PIXEL_V < c_v_active);
    assign w_rd_idx  = w_active ? CNT_W'(PIXEL_H >> BIT_W) : '0;
    assign w_buf_pix = line_buf_q[PIXEL_V[0]][w_rd_idx][PIXEL_H[BIT_W-1:0]];

`ifdef VGA_LF_TEST_PATTERN_EN
    assign w_pix_src = TEST_MODE ? (PIXEL_H[4] ^ PIXEL_V[4]) : w_buf_pix;
`else
    assign w_pix_src = w_buf_pix;
`endif

    assign PIXEL    = !RESET && w_active && w_pix_src;
    assign MEM_REQ  = (state_q == ST_REQ);
    assign MEM_ADDR = line_addr_q + ADDR_W'(word_cnt_q);
    assign UNDERRUN = underrun_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_line_fetch.sv
//==============================================================================
// Module   : tb_vga_line_fetch
// Purpose  : Directed self-checking bench for vga_line_fetch; the frame store
//            model returns word = address with a configurable ack delay.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_line_fetch;

    localparam int H_TOTAL = 976;
    localparam int V_TOTAL = 528;

    logic        CLOCK_PIXEL = 1'b0;
    logic        RESET;
    logic [10:0] PIXEL_H;
    logic [10:0] PIXEL_V;
    logic [17:0] FRAME_BASE;
    logic        TEST_MODE;
    logic        PIXEL;
    logic        MEM_REQ;
    logic [17:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [15:0] MEM_DATA;
    logic        UNDERRUN;
    logic        UNDERRUN_CLR;

    vga_line_fetch dut (
        .CLOCK_PIXEL  (CLOCK_PIXEL),
        .RESET        (RESET),
        .PIXEL_H      (PIXEL_H),
        .PIXEL_V      (PIXEL_V),
        .FRAME_BASE   (FRAME_BASE),
`ifdef VGA_LF_TEST_PATTERN_EN
        .TEST_MODE    (TEST_MODE),
`endif
        .PIXEL        (PIXEL),
        .MEM_REQ      (MEM_REQ),
        .MEM_ADDR     (MEM_ADDR),
        .MEM_ACK      (MEM_ACK),
        .MEM_DATA     (MEM_DATA),
        .UNDERRUN     (UNDERRUN),
        .UNDERRUN_CLR (UNDERRUN_CLR)
    );

    always #5 CLOCK_PIXEL = ~CLOCK_PIXEL;

    int n_checks = 0;
    int n_errors = 0;

    int h_pos, v_pos, cur_h, cur_v;
    int ack_delay, ack_limit, wait_cnt, acks_in_line;
    int hold_err, blank_err, blank_req_err;
    logic pix_now;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One pixel clock at (h_pos, v_pos); the frame store responds at the negedge.
    task automatic tick();
        logic        pre_req;
        logic [17:0] pre_addr;
        logic        ack;
        @(negedge CLOCK_PIXEL);
        PIXEL_H = 11'(h_pos);
        PIXEL_V = 11'(v_pos);
        cur_h   = h_pos;
        cur_v   = v_pos;
        if (h_pos == 0) acks_in_line = 0;
        pre_req  = MEM_REQ;
        pre_addr = MEM_ADDR;
        if (MEM_REQ && wait_cnt >= ack_delay && acks_in_line < ack_limit) begin
            ack = 1'b1;
            MEM_DATA = MEM_ADDR[15:0];
            wait_cnt = 0;
            acks_in_line++;
        end else begin
            ack = 1'b0;
            MEM_DATA = 16'hDEAD;
            wait_cnt = MEM_REQ ? wait_cnt + 1 : 0;
        end
        MEM_ACK = ack;
        #1;
        pix_now = PIXEL;
        if ((cur_h >= 800 || cur_v >= 480) && pix_now !== 1'b0) blank_err++;
        @(posedge CLOCK_PIXEL);
        #1;
        if (pre_req && !ack && cur_h != H_TOTAL - 1 && !RESET &&
            (!MEM_REQ || MEM_ADDR != pre_addr)) hold_err++;
        if (cur_v >= 479 && cur_v <= 526 && MEM_REQ) blank_req_err++;
        h_pos++;
        if (h_pos == H_TOTAL) begin
            h_pos = 0;
            v_pos = (v_pos == V_TOTAL - 1) ? 0 : v_pos + 1;
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n = 0;
        while (!(h_pos == h && v_pos == v) && n < 20000) begin
            tick();
            n++;
        end
        if (n >= 20000) check_val("run_to_timeout", 32'(n), 32'd0);
    endtask

    initial begin
        logic [15:0] bits;
        int   req_cycles;
        int   late_err;
        int   rst_req;
        logic p16, p162;

        RESET = 1'b1; PIXEL_H = 11'd5; PIXEL_V = 11'd5; FRAME_BASE = 18'h100;
        TEST_MODE = 1'b0; MEM_ACK = 1'b0; MEM_DATA = '0; UNDERRUN_CLR = 1'b0;
        ack_delay = 0; ack_limit = 1000; wait_cnt = 0; acks_in_line = 0;
        hold_err = 0; blank_err = 0; blank_req_err = 0;
        h_pos = 0; v_pos = 527;
        repeat (3) @(posedge CLOCK_PIXEL);
        #1;
        check_val("rst_req",      32'(MEM_REQ),  32'd0);
        check_val("rst_addr",     32'(MEM_ADDR), 32'd0);
        check_val("rst_underrun", 32'(UNDERRUN), 32'd0);
        check_val("rst_pixel",    32'(PIXEL),    32'd0);
        @(negedge CLOCK_PIXEL);
        RESET = 1'b0;

        // Line 0 fetch at V=527,H=0 from FRAME_BASE
        tick();
        check_val("l0_req_start", 32'(MEM_REQ),  32'd1);
        check_val("l0_addr_first", 32'(MEM_ADDR), 32'h100);
        repeat (49) tick();
        check_val("l0_addr_last", 32'(MEM_ADDR), 32'h131);
        tick();
        check_val("l0_req_done",  32'(MEM_REQ),  32'd0);

        // Line 1 fetch and line 0 display
        run_to(0, 0);
        for (int i = 0; i < 16; i++) begin
            tick();
            bits[i] = pix_now;
            if (i == 0) check_val("l1_addr_first", 32'(MEM_ADDR), 32'h132);
        end
        check_val("v0_pixels", 32'(bits), 32'h0100);

        // Line 2 fetch with three wait cycles per word, line 1 display
        run_to(0, 1);
        ack_delay = 3;
        req_cycles = 0;
        for (int i = 0; i < 250; i++) begin
            tick();
            if (i < 16) bits[i] = pix_now;
            if (MEM_REQ) req_cycles++;
        end
        ack_delay = 0;
        check_val("v1_pixels",      32'(bits),       32'h0132);
        check_val("slow_req_cycles", 32'(req_cycles), 32'd200);
        check_val("slow_underrun",  32'(UNDERRUN),   32'd0);

        // Line 5 fetch starved after 11 words; clear held high in abort cycle
        run_to(0, 4);
        ack_limit = 11;
        run_to(975, 4);
        check_val("abort_pre_req", 32'(MEM_REQ), 32'd1);
        UNDERRUN_CLR = 1'b1;
        tick();
        UNDERRUN_CLR = 1'b0;
        ack_limit = 1000;
        check_val("abort_req_drop",   32'(MEM_REQ),  32'd0);
        check_val("abort_set_wins",   32'(UNDERRUN), 32'd1);

        late_err = 0; p16 = 1'b0; p162 = 1'b0;
        for (int i = 0; i < 800; i++) begin
            tick();
            if (i == 0) check_val("l6_addr_first", 32'(MEM_ADDR), 32'h22C);
            if (cur_h == 16)  p16  = pix_now;
            if (cur_h == 162) p162 = pix_now;
            if (cur_h >= 176 && pix_now !== 1'b0) late_err++;
        end
        check_val("v5_pix_h16",    32'(p16),      32'd1);
        check_val("v5_pix_h162",   32'(p162),     32'd1);
        check_val("v5_black_tail", 32'(late_err), 32'd0);
        check_val("underrun_sticky", 32'(UNDERRUN), 32'd1);
        UNDERRUN_CLR = 1'b1;
        tick();
        UNDERRUN_CLR = 1'b0;
        check_val("underrun_clr", 32'(UNDERRUN), 32'd0);

        // Asynchronous reset in the middle of the line 11 fetch
        run_to(20, 10);
        check_val("mid_fetch_req", 32'(MEM_REQ), 32'd1);
        #2;
        RESET = 1'b1;
        #1;
        check_val("async_req_drop", 32'(MEM_REQ),  32'd0);
        check_val("async_addr",     32'(MEM_ADDR), 32'd0);
        check_val("async_pixel",    32'(PIXEL),    32'd0);
        tick();
        tick();
        RESET = 1'b0;
        rst_req = 0;
        while (!(h_pos == 0 && v_pos == 11)) begin
            tick();
            if (MEM_REQ) rst_req++;
        end
        check_val("post_rst_quiet", 32'(rst_req), 32'd0);
        tick();
        check_val("post_rst_req",  32'(MEM_REQ),  32'd1);
        check_val("post_rst_addr", 32'(MEM_ADDR), 32'd50);
        repeat (60) tick();

        // Vertical blanking: no fetches, black output; new base wraps
        FRAME_BASE = 18'h3FFE0;
        h_pos = 0; v_pos = 479;
        run_to(0, 482);
        h_pos = 0; v_pos = 525;
        run_to(0, 527);
        check_val("blank_no_req", 32'(blank_req_err), 32'd0);
        tick();
        check_val("frame_req",       32'(MEM_REQ),  32'd1);
        check_val("frame_base_addr", 32'(MEM_ADDR), 32'h3FFE0);
        repeat (49) tick();
        check_val("addr_wrap", 32'(MEM_ADDR), 32'h00011);
        repeat (10) tick();

`ifdef VGA_LF_TEST_PATTERN_EN
        TEST_MODE = 1'b1;
        h_pos = 16; v_pos = 0;  tick(); check_val("tp_16_0",  32'(pix_now), 32'd1);
        h_pos = 16; v_pos = 16; tick(); check_val("tp_16_16", 32'(pix_now), 32'd0);
        h_pos = 0;  v_pos = 0;  tick(); check_val("tp_0_0",   32'(pix_now), 32'd0);
        h_pos = 0;  v_pos = 16; tick(); check_val("tp_0_16",  32'(pix_now), 32'd1);
        TEST_MODE = 1'b0;
`endif

        check_val("blank_pixels", 32'(blank_err), 32'd0);
        check_val("req_hold",     32'(hold_err),  32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
